// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the program counter, issues req/ack reads to
// instruction memory and presents {inst, pc, pc+4, valid} to the IF/ID
// register. A one-entry skid buffer catches a word that arrives while the
// pipeline is stopped. Redirects from later stages take priority and flush
// whatever is in flight.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   pipline_stop         downstream stall; registered outputs hold while 1
//   redirect_valid/_pc   change-of-flow request and target PC
//   imem_req/imem_addr   memory read request; address is the internal PC
//   imem_ack/imem_rdata  read completion and data
//   inst_o/pc_o/pc4_o    fetched instruction, its PC and PC+4
//   inst_valid_o         1 = real fetch, 0 = bubble
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipline_stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2   // skid buffer full, no request outstanding
  } state_t;

  // Which source the output register loads from this cycle.
  typedef enum logic [1:0] {
    OUT_HOLD   = 2'd0,
    OUT_MEM    = 2'd1,
    OUT_SKID   = 2'd2,
    OUT_BUBBLE = 2'd3
  } out_sel_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_pc4;
  logic [31:0] r_inst;
  logic [31:0] r_pc_o;
  logic [31:0] r_pc4_o;
  logic        r_valid;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;
  logic        w_skid_load;
  out_sel_t    w_out_sel;

  // Modulo 2^32 wrap is intended.
  assign w_pc_plus4 = r_pc + 32'd4;

  assign imem_req     = (r_state == ST_FETCH);
  assign imem_addr    = r_pc;
  assign inst_o       = r_inst;
  assign pc_o         = r_pc_o;
  assign pc4_o        = r_pc4_o;
  assign inst_valid_o = r_valid;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_skid_load  = 1'b0;
    w_out_sel    = OUT_HOLD;
    case (r_state)
      ST_BOOT: begin
        // Boot always lasts exactly one cycle; a redirect only retargets it.
        w_state_next = ST_FETCH;
        if (redirect_valid) w_pc_next = redirect_pc;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          // Any data acked this cycle belongs to the abandoned stream.
          w_pc_next = redirect_pc;
          if (!pipline_stop) w_out_sel = OUT_BUBBLE;
        end else if (imem_ack) begin
          w_pc_next = w_pc_plus4;
          if (pipline_stop) begin
            w_skid_load  = 1'b1;
            w_state_next = ST_HOLD;
          end else begin
            w_out_sel = OUT_MEM;
          end
        end else if (!pipline_stop) begin
          w_out_sel = OUT_BUBBLE;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          // Dropping back to FETCH without loading the skid discards it.
          w_pc_next    = redirect_pc;
          w_state_next = ST_FETCH;
          if (!pipline_stop) w_out_sel = OUT_BUBBLE;
        end else if (!pipline_stop) begin
          w_out_sel    = OUT_SKID;
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_skid_inst <= 32'd0;
      r_skid_pc   <= 32'd0;
      r_skid_pc4  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_skid_load) begin
        r_skid_inst <= imem_rdata;
        r_skid_pc   <= r_pc;
        r_skid_pc4  <= w_pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst  <= 32'd0;
      r_pc_o  <= 32'd0;
      r_pc4_o <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      case (w_out_sel)
        OUT_MEM: begin
          r_inst  <= imem_rdata;
          r_pc_o  <= r_pc;
          r_pc4_o <= w_pc_plus4;
          r_valid <= 1'b1;
        end
        OUT_SKID: begin
          r_inst  <= r_skid_inst;
          r_pc_o  <= r_skid_pc;
          r_pc4_o <= r_skid_pc4;
          r_valid <= 1'b1;
        end
        OUT_BUBBLE: begin
          // pc_o/pc4_o keep the last fetch's PC.
          r_inst  <= BUBBLE_INST;
          r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Randomized bench for if_fetch_unit. The stimulus process drives random
// stop/ack/redirect patterns and advances a transaction-level model (a PC,
// a pending-word queue and a boot flag). Every word the model says reaches
// the outputs is pushed into a scoreboard queue; a negedge monitor pops one
// entry each time the DUT presents a valid word that downstream consumes.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipline_stop = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        inst_valid_o;

  if_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .BUBBLE_INST (BUBBLE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipline_stop   (pipline_stop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_o         (inst_o),
    .pc_o           (pc_o),
    .pc4_o          (pc4_o),
    .inst_valid_o   (inst_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } word_t;

  word_t       sb[$];       // words expected at the outputs, in order
  word_t       m_pend[$];   // word fetched during a stop, not yet delivered
  logic [31:0] m_pc;
  bit          m_boot;
  logic [31:0] m_idle;      // inst_o value expected while valid=0
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0000_0000;
    m_boot = 1'b1;
    m_idle = 32'd0;
    m_pend.delete();
    sb.delete();
  endtask

  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic step(input int pa, input int ps, input int pr,
                      input bit force_red, input logic [31:0] force_pc);
    bit          a, s, r, exp_req;
    logic [31:0] rp, rd;
    word_t       w;
    exp_req = !m_boot && (m_pend.size() == 0);
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    a  = ($urandom_range(99) < pa);
    s  = ($urandom_range(99) < ps);
    r  = force_red || ($urandom_range(99) < pr);
    rp = force_red ? force_pc :
         (($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(255)) << 2));
    rd = m_pc ^ 32'hA5A5_A5A5 ^ (($urandom_range(1) == 1) ? $urandom : 32'd0);
    imem_ack       = a;
    pipline_stop   = s;
    redirect_valid = r;
    redirect_pc    = rp;
    imem_rdata     = rd;
    @(posedge clk);
    if (m_boot) begin
      m_boot = 1'b0;
      if (r) m_pc = rp;
    end else begin
      if (!s && (r || (m_pend.size() == 0 && !a))) m_idle = BUBBLE;
      if (r) begin
        m_pend.delete();
        m_pc = rp;
      end else if (m_pend.size() != 0) begin
        if (!s) sb.push_back(m_pend.pop_front());
      end else if (a) begin
        w.inst = rd;
        w.pc   = m_pc;
        w.pc4  = m_pc + 32'd4;
        m_pc   = m_pc + 32'd4;
        if (s) m_pend.push_back(w);
        else   sb.push_back(w);
      end
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inst"},  inst_o, 32'd0);
    chk({tag, "_pc"},    pc_o,   32'd0);
    chk({tag, "_pc4"},   pc4_o,  32'd0);
    chk({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
    chk({tag, "_req"},   {31'd0, imem_req},     32'd0);
  endtask

  // Monitor: a valid word is consumed at the edge where pipline_stop is 0.
  always @(negedge clk) begin
    word_t e;
    if (rst_n) begin
      if (inst_valid_o && !pipline_stop) begin
        if (sb.size() == 0) begin
          chk("sb_underflow_pc", pc_o, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          chk("out_inst", inst_o, e.inst);
          chk("out_pc",   pc_o,   e.pc);
          chk("out_pc4",  pc4_o,  e.pc4);
          $display("word pc=%h pc4=%h inst=%h", pc_o, pc4_o, inst_o);
        end
      end else if (!inst_valid_o) begin
        chk("bubble_inst", inst_o, m_idle);
      end
    end
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Free-running fetch with memory acking every cycle.
    for (int i = 0; i < 20; i++) step(100, 0, 0, 1'b0, 32'd0);
    // Random stalls.
    for (int i = 0; i < 60; i++) step(100, 30, 0, 1'b0, 32'd0);
    // Memory wait states.
    for (int i = 0; i < 60; i++) step(33, 0, 0, 1'b0, 32'd0);
    // Everything mixed, including redirects during stalls.
    for (int i = 0; i < 200; i++) step(70, 40, 10, 1'b0, 32'd0);

    // Asynchronous reset mid-stream, away from the clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(100, 0, 0, 1'b0, 32'd0);

    // PC wrap at the top of the address space.
    step(100, 0, 0, 1'b1, 32'hFFFF_FFFC);
    step(100, 0, 0, 1'b0, 32'd0);
    chk("wrap_pc",   pc_o,      32'hFFFF_FFFC);
    chk("wrap_pc4",  pc4_o,     32'h0000_0000);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 5; i++) step(100, 0, 0, 1'b0, 32'd0);

    for (int i = 0; i < 200; i++) step(60, 35, 8, 1'b0, 32'd0);

    // Drain: no stalls, no acks; every pending word must come out.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1'b0, 32'd0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
